// File: rtl/gpi_input_conditioner.sv
// Receive path for a GPIO pad: synchronises the raw pad level, debounces it and
// produces a clean level, single-cycle edge pulses and a sticky edge interrupt.
module gpi_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             CLK_I,
   input  logic             RSTN_I,
   input  logic             DI_I,
   input  logic             IE_I,
   input  logic [CNT_W-1:0] DEB_I,
   input  logic [1:0]       IRQ_MODE_I,
   input  logic             IRQ_CLR_I,
   output logic             DATA_O,
   output logic             RISE_O,
   output logic             FALL_O,
   output logic             IRQ_O
);

   typedef enum logic [1:0] {
      LOW,
      CHK_HI,
      HIGH,
      CHK_LO
   } stateT;

   stateT            state;
   logic [CNT_W-1:0] cnt;
   logic [SYNC_STAGES-1:0] syncChain;
   logic             gatedIn;
   logic             syncOut;
   logic             dataReg;
   logic             riseReg;
   logic             fallReg;
   logic             irqReg;
   logic             irqSet;

   // Gating before the synchroniser means a disabled pad simply looks like a held-low input.
   assign gatedIn = DI_I & IE_I;
   assign syncOut = syncChain[SYNC_STAGES-1];

   // Metastability chain; only the last stage is ever used by the filter.
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         syncChain <= '0;
      end else begin
         syncChain <= {syncChain[SYNC_STAGES-2:0], gatedIn};
      end
   end

   // Debounce filter: a new level is accepted after DEB_I+1 consecutive equal samples.
   // The accepted level and its edge pulses are registered together with the state.
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         state   <= LOW;
         cnt     <= '0;
         dataReg <= 1'b0;
         riseReg <= 1'b0;
         fallReg <= 1'b0;
      end else begin
         riseReg <= 1'b0;
         fallReg <= 1'b0;
         case (state)
            LOW: begin
               if (syncOut) begin
                  if (DEB_I == '0) begin
                     state   <= HIGH;
                     cnt     <= '0;
                     dataReg <= 1'b1;
                     riseReg <= 1'b1;
                  end else begin
                     state <= CHK_HI;
                     cnt   <= CNT_W'(1);
                  end
               end
            end
            CHK_HI: begin
               if (!syncOut) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (cnt >= DEB_I) begin
                  state   <= HIGH;
                  cnt     <= '0;
                  dataReg <= 1'b1;
                  riseReg <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HIGH: begin
               if (!syncOut) begin
                  if (DEB_I == '0) begin
                     state   <= LOW;
                     cnt     <= '0;
                     dataReg <= 1'b0;
                     fallReg <= 1'b1;
                  end else begin
                     state <= CHK_LO;
                     cnt   <= CNT_W'(1);
                  end
               end
            end
            CHK_LO: begin
               if (syncOut) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt >= DEB_I) begin
                  state   <= LOW;
                  cnt     <= '0;
                  dataReg <= 1'b0;
                  fallReg <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= LOW;
               cnt     <= '0;
               dataReg <= 1'b0;
            end
         endcase
      end
   end

   assign irqSet = (riseReg & IRQ_MODE_I[0]) | (fallReg & IRQ_MODE_I[1]);

   // Sticky interrupt; a new edge in the same cycle as a clear keeps it pending.
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         irqReg <= 1'b0;
      end else if (irqSet) begin
         irqReg <= 1'b1;
      end else if (IRQ_CLR_I) begin
         irqReg <= 1'b0;
      end
   end

   assign DATA_O = dataReg;
   assign RISE_O = riseReg;
   assign FALL_O = fallReg;
   assign IRQ_O  = irqReg;

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Bench for gpi_input_conditioner: directed vector table, hand-written corner
// sequences and randomized traffic checked against a run-length reference model.
module tb_gpi_input_conditioner;

   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 8;

   logic             clk = 1'b0;
   logic             rstn;
   logic             di;
   logic             ie;
   logic [CNT_W-1:0] deb;
   logic [1:0]       mode;
   logic             clr;
   logic             dataO;
   logic             riseO;
   logic             fallO;
   logic             irqO;

   int checkCount = 0;
   int errorCount = 0;

   gpi_input_conditioner #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W(CNT_W)
   ) dut (
      .CLK_I(clk),
      .RSTN_I(rstn),
      .DI_I(di),
      .IE_I(ie),
      .DEB_I(deb),
      .IRQ_MODE_I(mode),
      .IRQ_CLR_I(clr),
      .DATA_O(dataO),
      .RISE_O(riseO),
      .FALL_O(fallO),
      .IRQ_O(irqO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             rstn;
      logic             di;
      logic             ie;
      logic [CNT_W-1:0] deb;
      logic [1:0]       mode;
      logic             clr;
      logic             expData;
      logic             expRise;
      logic             expFall;
      logic             expIrq;
   } vecT;

   vecT vecs[$];

   // Reference model: the pad level seen by the filter is d delayed by the
   // synchroniser depth; the level flips once a run of DEB+1 differing samples is seen.
   logic mq[$];
   logic mLevel = 1'b0;
   int   mRun   = 0;
   logic mRise  = 1'b0;
   logic mFall  = 1'b0;
   logic mIrq   = 1'b0;

   function automatic void modelStep();
      logic seen;
      logic old;
      logic setIrq;
      if (!rstn) begin
         mq.delete();
         for (int k = 0; k < SYNC_STAGES; k++) mq.push_back(1'b0);
         mLevel = 1'b0;
         mRun   = 0;
         mRise  = 1'b0;
         mFall  = 1'b0;
         mIrq   = 1'b0;
      end else begin
         setIrq = (mRise & mode[0]) | (mFall & mode[1]);
         if (setIrq) mIrq = 1'b1;
         else if (clr) mIrq = 1'b0;
         mq.push_back(di & ie);
         seen = mq.pop_front();
         old  = mLevel;
         if (seen != mLevel) begin
            mRun++;
            if (mRun >= int'(deb) + 1) begin
               mLevel = seen;
               mRun   = 0;
            end
         end else begin
            mRun = 0;
         end
         mRise = mLevel & ~old;
         mFall = ~mLevel & old;
      end
   endfunction

   function automatic void addRun(input int n, input logic r, input logic d, input logic e,
                                  input logic [CNT_W-1:0] db, input logic [1:0] m, input logic c,
                                  input logic xd, input logic xr, input logic xf, input logic xi);
      vecT v;
      v.rstn = r; v.di = d; v.ie = e; v.deb = db; v.mode = m; v.clr = c;
      v.expData = xd; v.expRise = xr; v.expFall = xf; v.expIrq = xi;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      modelStep();
   endtask

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0b expected=%0b", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vecT v);
      rstn = v.rstn;
      di   = v.di;
      ie   = v.ie;
      deb  = v.deb;
      mode = v.mode;
      clr  = v.clr;
   endtask

   task automatic waitData(input logic want, input int budget, input string name);
      int n = 0;
      while (dataO !== want && n < budget) begin
         tick();
         n++;
      end
      checkOutput(name, dataO, want);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic hist[$];
      int   sz;
      int   runLeft;

      rstn = 1'b0; di = 1'b0; ie = 1'b1; deb = 8'd3; mode = 2'b01; clr = 1'b0;

      // Reset, 3-deep debounce rise, irq set and clear, fall, rejected glitch, 4-cycle pulse
      addRun(2, 0, 0, 1, 8'd3, 2'b01, 0, 0, 0, 0, 0);
      addRun(5, 1, 1, 1, 8'd3, 2'b01, 0, 0, 0, 0, 0);
      addRun(1, 1, 1, 1, 8'd3, 2'b01, 0, 1, 1, 0, 0);
      addRun(1, 1, 1, 1, 8'd3, 2'b01, 0, 1, 0, 0, 1);
      addRun(1, 1, 1, 1, 8'd3, 2'b01, 1, 1, 0, 0, 0);
      addRun(5, 1, 0, 1, 8'd3, 2'b00, 0, 1, 0, 0, 0);
      addRun(1, 1, 0, 1, 8'd3, 2'b00, 0, 0, 0, 1, 0);
      addRun(1, 1, 0, 1, 8'd3, 2'b00, 0, 0, 0, 0, 0);
      addRun(3, 1, 1, 1, 8'd3, 2'b00, 0, 0, 0, 0, 0);
      addRun(5, 1, 0, 1, 8'd3, 2'b00, 0, 0, 0, 0, 0);
      addRun(4, 1, 1, 1, 8'd3, 2'b00, 0, 0, 0, 0, 0);
      addRun(1, 1, 0, 1, 8'd3, 2'b00, 0, 0, 0, 0, 0);
      addRun(1, 1, 0, 1, 8'd3, 2'b00, 0, 1, 1, 0, 0);
      addRun(3, 1, 0, 1, 8'd3, 2'b00, 0, 1, 0, 0, 0);
      addRun(1, 1, 0, 1, 8'd3, 2'b00, 0, 0, 0, 1, 0);
      addRun(1, 1, 0, 1, 8'd3, 2'b00, 0, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d data", i), dataO, vecs[i].expData);
         checkOutput($sformatf("vec%0d rise", i), riseO, vecs[i].expRise);
         checkOutput($sformatf("vec%0d fall", i), fallO, vecs[i].expFall);
         checkOutput($sformatf("vec%0d irq", i), irqO, vecs[i].expIrq);
      end

      // Zero debounce: the level follows d two indices later, with alternating pulses
      deb = 8'd0;
      for (int k = 0; k < 4; k++) hist.push_back(1'b0);
      for (int i = 0; i < 24; i++) begin
         di = ((i / 2) % 2) == 1;
         tick();
         hist.push_back(di);
         sz = hist.size();
         checkOutput($sformatf("deb0 data %0d", i), dataO, hist[sz-3]);
         checkOutput($sformatf("deb0 rise %0d", i), riseO, hist[sz-3] & ~hist[sz-4]);
         checkOutput($sformatf("deb0 fall %0d", i), fallO, ~hist[sz-3] & hist[sz-4]);
      end

      // Falling-edge irq: a clear coinciding with a new fall leaves the irq pending
      di = 1'b0;
      waitData(1'b0, 20, "irq prep low");
      deb  = 8'd1;
      mode = 2'b10;
      di   = 1'b1;
      waitData(1'b1, 20, "irq first high");
      di = 1'b0;
      waitData(1'b0, 20, "irq first fall");
      checkOutput("irq first fall pulse", fallO, 1'b1);
      tick();
      checkOutput("irq after first fall", irqO, 1'b1);
      di = 1'b1;
      waitData(1'b1, 20, "irq second high");
      di = 1'b0;
      waitData(1'b0, 20, "irq second fall");
      clr = 1'b1;
      tick();
      checkOutput("irq set beats clear", irqO, 1'b1);
      tick();
      checkOutput("irq cleared", irqO, 1'b0);
      clr  = 1'b0;
      mode = 2'b00;

      // Reset aborting a rise check part-way; the held-high pad is treated as a fresh rise
      deb = 8'd5;
      repeat (10) tick();
      di = 1'b1;
      repeat (4) tick();
      checkOutput("mid-check data", dataO, 1'b0);
      rstn = 1'b0;
      tick();
      checkOutput("reset data", dataO, 1'b0);
      checkOutput("reset rise", riseO, 1'b0);
      checkOutput("reset fall", fallO, 1'b0);
      checkOutput("reset irq", irqO, 1'b0);
      rstn = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         checkOutput($sformatf("post-reset rise %0d", i), riseO, i == 8);
         checkOutput($sformatf("post-reset data %0d", i), dataO, i == 8);
      end

      // Input enable dropping while high falls after full latency, then stays quiet
      repeat (3) tick();
      ie = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         checkOutput($sformatf("ie-off fall %0d", i), fallO, i == 8);
         checkOutput($sformatf("ie-off data %0d", i), dataO, i < 8);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput($sformatf("ie-off hold data %0d", i), dataO, 1'b0);
         checkOutput($sformatf("ie-off hold rise %0d", i), riseO, 1'b0);
      end

      // Randomized traffic against the reference model
      ie   = 1'b1;
      rstn = 1'b0;
      tick();
      tick();
      rstn    = 1'b1;
      runLeft = 1;
      for (int i = 0; i < 3000; i++) begin
         runLeft--;
         if (runLeft <= 0) begin
            di      = ~di;
            runLeft = $urandom_range(1, 9);
         end
         if (($urandom % 150) == 0) deb = CNT_W'($urandom_range(0, 6));
         if (($urandom % 40) == 0) mode = 2'($urandom_range(0, 3));
         ie   = ($urandom % 25) != 0;
         clr  = ($urandom % 10) == 0;
         rstn = ($urandom % 400) != 0;
         tick();
         checkOutput($sformatf("rand data %0d", i), dataO, mLevel);
         checkOutput($sformatf("rand rise %0d", i), riseO, mRise);
         checkOutput($sformatf("rand fall %0d", i), fallO, mFall);
         checkOutput($sformatf("rand irq %0d", i), irqO, mIrq);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
